// File: rtl/sound_level_pkg.sv
// Shared helpers for the multichannel sound level meter: saturating magnitude,
// clip detection and window-counter width.
package sound_level_pkg;

  localparam int unsigned SAMPLES_DEF = 64;
  localparam int unsigned CNT_W_DEF   = $clog2(SAMPLES_DEF);

  function automatic int unsigned cnt_w(input int unsigned samples);
    return (samples < 32'd2) ? 32'd1 : $clog2(samples);
  endfunction

  // The most negative code is mapped onto the most positive before scaling down.
  function automatic logic [63:0] sat_mag(input logic signed [63:0] s, input int w, input int lw);
    logic signed [63:0] lim;
    logic [63:0]        a;
    lim = (64'sd1 <<< (w - 1)) - 64'sd1;
    if (s < -lim) begin
      a = lim;
    end else if (s < 64'sd0) begin
      a = -s;
    end else begin
      a = s;
    end
    return a >> (w - 1 - lw);
  endfunction

  function automatic logic is_clip(input logic signed [63:0] s, input int w);
    logic signed [63:0] lim;
    lim = (64'sd1 <<< (w - 1)) - 64'sd1;
    return (s == lim) || (s == (-lim - 64'sd1));
  endfunction

endpackage

// File: rtl/sound_level_chan.sv
// One metering channel: window max/clip accumulators plus optional peak hold
// (compiled in with SOUND_LEVEL_PEAK_HOLD_EN).
module sound_level_chan
  import sound_level_pkg::*;
#(
  parameter int W            = 16,
  parameter int LW           = 8,
  parameter int HOLD_WINDOWS = 8,
  parameter int DECAY        = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ready,
  input  logic                 last,
  input  logic signed [W-1:0]  sample,
  output logic [LW-1:0]        level,
  output logic                 clip,
  output logic [LW-1:0]        peak
);

  logic [LW-1:0] acc_q, acc_d, level_q, level_d;
  logic          clip_acc_q, clip_acc_d, clip_q, clip_d;
  logic [LW-1:0] mag_s, win_max_s;
  logic          hit_s;

  always_comb begin
    mag_s      = LW'(sat_mag(64'(sample), W, LW));
    hit_s      = is_clip(64'(sample), W);
    win_max_s  = (mag_s > acc_q) ? mag_s : acc_q;
    acc_d      = acc_q;
    clip_acc_d = clip_acc_q;
    level_d    = level_q;
    clip_d     = clip_q;
    if (ready) begin
      if (last) begin
        level_d    = win_max_s;
        clip_d     = clip_acc_q | hit_s;
        acc_d      = '0;
        clip_acc_d = 1'b0;
      end else begin
        acc_d      = win_max_s;
        clip_acc_d = clip_acc_q | hit_s;
      end
    end else begin
      acc_d      = acc_q;
      clip_acc_d = clip_acc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      clip_acc_q <= 1'b0;
      level_q    <= '0;
      clip_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      clip_acc_q <= clip_acc_d;
      level_q    <= level_d;
      clip_q     <= clip_d;
    end
  end

  assign level = level_q;
  assign clip  = clip_q;

`ifdef SOUND_LEVEL_PEAK_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_WINDOWS + 1);

  logic [LW-1:0]     peak_q, peak_d, dec_s;
  logic [HOLD_W-1:0] hold_q, hold_d;
  int                dec_i;

  // Peak follows a new high at once, otherwise holds, then decays toward level.
  always_comb begin
    dec_i  = int'(peak_q) - DECAY;
    dec_s  = (dec_i < 0) ? '0 : LW'(dec_i);
    peak_d = peak_q;
    hold_d = hold_q;
    if (ready && last) begin
      if (win_max_s >= peak_q) begin
        peak_d = win_max_s;
        hold_d = HOLD_W'(HOLD_WINDOWS);
      end else if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
      end else begin
        peak_d = (dec_s > win_max_s) ? dec_s : win_max_s;
      end
    end else begin
      peak_d = peak_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_q <= '0;
      hold_q <= '0;
    end else begin
      peak_q <= peak_d;
      hold_q <= hold_d;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule

// File: rtl/sound_level_mc.sv
// Multichannel sound level meter top: shared window counter and level_valid,
// one sound_level_chan per channel. Optional peak hold: SOUND_LEVEL_PEAK_HOLD_EN.
module sound_level_mc
  import sound_level_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int W            = 16,
  parameter int LW           = 8,
  parameter int SAMPLES      = 64,
  parameter int HOLD_WINDOWS = 8,
  parameter int DECAY        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ready,
  input  logic [CHANNELS*W-1:0]  audio,
  output logic [CHANNELS*LW-1:0] level,
  output logic [CHANNELS-1:0]    clip,
  output logic [CHANNELS*LW-1:0] peak,
  output logic                   level_valid
);

  localparam int CNT_W = int'(cnt_w(SAMPLES));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_valid_q, level_valid_d;
  logic             last_s;

  always_comb begin
    last_s        = (cnt_q == CNT_W'(SAMPLES - 1));
    level_valid_d = ready & last_s;
    cnt_d         = cnt_q;
    if (ready) begin
      cnt_d = last_s ? '0 : cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      level_valid_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      level_valid_q <= level_valid_d;
    end
  end

  assign level_valid = level_valid_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    sound_level_chan #(
      .W            (W),
      .LW           (LW),
      .HOLD_WINDOWS (HOLD_WINDOWS),
      .DECAY        (DECAY)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .ready  (ready),
      .last   (last_s),
      .sample (audio[c*W +: W]),
      .level  (level[c*LW +: LW]),
      .clip   (clip[c]),
      .peak   (peak[c*LW +: LW])
    );
  end

endmodule

// File: tb/tb_sound_level_mc.sv
// Directed self-checking bench for sound_level_mc (W=16, LW=8, CHANNELS=2,
// SAMPLES=4, HOLD_WINDOWS=2, DECAY=16); peak expectations follow SOUND_LEVEL_PEAK_HOLD_EN.
module tb_sound_level_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [31:0] audio;
  logic [15:0] level;
  logic [1:0]  clip;
  logic [15:0] peak;
  logic        level_valid;

  int n_vec = 0;
  int n_err = 0;

  sound_level_mc #(
    .CHANNELS(2), .W(16), .LW(8), .SAMPLES(4), .HOLD_WINDOWS(2), .DECAY(16)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready), .audio(audio),
    .level(level), .clip(clip), .peak(peak), .level_valid(level_valid)
  );

  always #5 clk = ~clk;

  function automatic int pk(input int v);
`ifdef SOUND_LEVEL_PEAK_HOLD_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input int s0, input int s1, input logic exp_v);
    ready = r;
    audio = {16'(s1), 16'(s0)};
    @(posedge clk);
    #1;
    chk("level_valid", int'(level_valid), int'(exp_v));
  endtask

  // Four ready samples; v0/v1 go at position pos, every other sample is zero.
  task automatic run_win(input int v0, input int v1, input int pos);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == pos) ? v0 : 0, (i == pos) ? v1 : 0, i == 3);
    end
  endtask

  int exp_pk[4] = '{200, 200, 184, 168};

  initial begin
    reset = 1'b1;
    ready = 1'b0;
    audio = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_clip", int'(clip), 0);
    chk("rst_peak", int'(peak), 0);
    chk("rst_valid", int'(level_valid), 0);
    reset = 1'b0;

    // Gapped window on ch0
    step(1'b1, 256, 0, 1'b0);
    step(1'b0, 9999, 0, 1'b0);
    step(1'b1, -1024, 0, 1'b0);
    step(1'b0, -32768, 0, 1'b0);
    step(1'b1, 512, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    step(1'b1, 0, 0, 1'b1);
    chk("gap_level0", int'(level[7:0]), 8);
    chk("gap_clip", int'(clip), 0);
    step(1'b0, 0, 0, 1'b0);
    chk("gap_level0_hold", int'(level[7:0]), 8);

    // Full-scale negative as the closing sample on ch1
    run_win(0, -32768, 3);
    chk("clip_level1", int'(level[15:8]), 255);
    chk("clip_flag1", int'(clip[1]), 1);
    chk("clip_flag0", int'(clip[0]), 0);
    chk("clip_level0", int'(level[7:0]), 0);
    run_win(0, 0, 0);
    chk("clr_level1", int'(level[15:8]), 0);
    chk("clr_clip", int'(clip), 0);

    // Peak hold and decay, from a clean reset
    step(1'b0, 0, 0, 1'b0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    run_win(25600, 0, 0);
    chk("pk_level0", int'(level[7:0]), 200);
    chk("pk_w0", int'(peak[7:0]), pk(200));
    for (int k = 0; k < 4; k++) begin
      run_win(0, 0, 0);
      chk("pk_decay", int'(peak[7:0]), pk(exp_pk[k]));
      chk("pk_zero_level", int'(level[7:0]), 0);
    end
    run_win(32000, 0, 0);
    chk("pk_new_high", int'(peak[7:0]), pk(250));
    chk("pk_new_level", int'(level[7:0]), 250);
    chk("pk_ch1", int'(peak[15:8]), 0);

    // Reset mid-window discards the partial samples
    step(1'b1, 32000, 0, 1'b0);
    step(1'b1, 32000, 0, 1'b0);
    reset = 1'b1;
    #2;
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_peak", int'(peak), 0);
    reset = 1'b0;
    step(1'b1, 128, 0, 1'b0);
    step(1'b1, 128, 0, 1'b0);
    step(1'b1, 128, 0, 1'b0);
    step(1'b1, 128, 0, 1'b1);
    chk("mid_rst_new_level", int'(level[7:0]), 1);

    // Back-to-back ready for three windows
    for (int i = 0; i < 12; i++) begin
      step(1'b1, i * 1000, 0, (i % 4) == 3);
      if (i == 3)  chk("b2b_w0", int'(level[7:0]), 23);
      if (i == 7)  chk("b2b_w1", int'(level[7:0]), 54);
      if (i == 11) chk("b2b_w2", int'(level[7:0]), 85);
    end
    step(1'b0, 0, 0, 1'b0);
    chk("b2b_ch1", int'(level[15:8]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
